// File: rtl/mips_mem_pkg.sv
// Shared memory-interface definitions for the MIPS pipeline data side.
package mips_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned CNT_W      = 4;

    // Opcodes the pipeline-side initiator decodes into load/store requests.
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Request fields held between accept and commit.
    typedef struct packed {
        logic              write;
        logic              err;
        logic [DATA_W-1:0] wdata;
    } mem_cap_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and strobed response bus between MEM stage and data memory.
interface dmem_responder_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, clearable read port.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register: cleared for stores/errors/reset, otherwise holds.
    always_ff @(posedge clock) begin
        if (i_clr) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request, answers after LATENCY edges.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned     IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit              DIRECT   = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    mem_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    mem_cap_t          r_cap;
    logic [IDX_W-1:0]  r_idx;
    logic              r_ready;
    logic              r_valid;
    logic              r_error;

    logic              w_addr_err;
    logic              w_from_idle;
    logic              w_enter_resp;
    logic              w_c_write;
    logic              w_c_err;
    logic [IDX_W-1:0]  w_c_idx;
    logic [DATA_W-1:0] w_c_wdata;
    logic              w_we;
    logic              w_re;
    logic              w_clr;
    logic [DATA_W-1:0] w_rdata;

    // Misaligned or beyond-the-array addresses are answered with an error.
    assign w_addr_err = (bus.req_addr[1:0] != 2'b00) ||
                        ({2'b00, bus.req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));

    // Commit happens on the edge entering RESP; with LATENCY=1 that is the accept edge,
    // so the live bus fields are used instead of the not-yet-captured copy.
    assign w_from_idle  = (r_state == IDLE);
    assign w_enter_resp = !reset &&
                          ((DIRECT && w_from_idle && bus.req_valid) ||
                           (r_state == WAIT && r_cnt == '0));
    assign w_c_write = w_from_idle ? bus.req_write              : r_cap.write;
    assign w_c_err   = w_from_idle ? w_addr_err                 : r_cap.err;
    assign w_c_idx   = w_from_idle ? bus.req_addr[IDX_W+1:2]    : r_idx;
    assign w_c_wdata = w_from_idle ? bus.req_wdata              : r_cap.wdata;

    assign w_we  = w_enter_resp &&  w_c_write && !w_c_err;
    assign w_re  = w_enter_resp && !w_c_write && !w_c_err;
    assign w_clr = reset || (w_enter_resp && (w_c_write || w_c_err));

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_idx   (w_c_idx),
        .i_wdata (w_c_wdata),
        .o_rdata (w_rdata)
    );

    // Transaction FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_cap.write <= bus.req_write;
                        r_cap.err   <= w_addr_err;
                        r_cap.wdata <= bus.req_wdata;
                        r_idx       <= bus.req_addr[IDX_W+1:2];
                        r_ready     <= 1'b0;
                        if (DIRECT) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                            r_error <= w_addr_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                        r_error <= r_cap.err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_valid;
    assign bus.resp_error = r_error;
    assign bus.resp_rdata = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1, 15 and 4.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        tb_rst_all;
    logic        tb_rst;
    logic        tb_valid;
    logic        tb_write;
    logic [31:0] tb_addr;
    logic [31:0] tb_wdata;
    int          sel;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0]  o_ready;
    logic [3:0]  o_valid;
    logic [3:0]  o_err;
    logic [31:0] o_rdata [4];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();
    dmem_responder_if bus3 ();

    assign bus0.req_valid = tb_valid && (sel == 0);
    assign bus0.req_write = tb_write;
    assign bus0.req_addr  = tb_addr;
    assign bus0.req_wdata = tb_wdata;
    assign bus1.req_valid = tb_valid && (sel == 1);
    assign bus1.req_write = tb_write;
    assign bus1.req_addr  = tb_addr;
    assign bus1.req_wdata = tb_wdata;
    assign bus2.req_valid = tb_valid && (sel == 2);
    assign bus2.req_write = tb_write;
    assign bus2.req_addr  = tb_addr;
    assign bus2.req_wdata = tb_wdata;
    assign bus3.req_valid = tb_valid && (sel == 3);
    assign bus3.req_write = tb_write;
    assign bus3.req_addr  = tb_addr;
    assign bus3.req_wdata = tb_wdata;

    assign o_ready = {bus3.req_ready,  bus2.req_ready,  bus1.req_ready,  bus0.req_ready};
    assign o_valid = {bus3.resp_valid, bus2.resp_valid, bus1.resp_valid, bus0.resp_valid};
    assign o_err   = {bus3.resp_error, bus2.resp_error, bus1.resp_error, bus0.resp_error};
    assign o_rdata[0] = bus0.resp_rdata;
    assign o_rdata[1] = bus1.resp_rdata;
    assign o_rdata[2] = bus2.resp_rdata;
    assign o_rdata[3] = bus3.resp_rdata;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clock (clk), .reset (tb_rst_all || (tb_rst && sel == 0)), .bus (bus0));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clock (clk), .reset (tb_rst_all || (tb_rst && sel == 1)), .bus (bus1));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15)) u_dut2 (
        .clock (clk), .reset (tb_rst_all || (tb_rst && sel == 2)), .bus (bus2));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut3 (
        .clock (clk), .reset (tb_rst_all || (tb_rst && sel == 3)), .bus (bus3));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance k; checks handshake, latency, response and hold.
    task automatic do_txn(input int k, input int lat, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input bit scramble, input string tag, output int acc_cyc);
        int n;
        sel = k;
        check_val({tag, ":ready_idle"}, 32'(o_ready[k]), 32'd1);
        tb_valid = 1'b1;
        tb_write = wr;
        tb_addr  = addr;
        tb_wdata = wd;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        tb_valid = 1'b0;
        check_val({tag, ":ready_busy"}, 32'(o_ready[k]), 32'd0);
        n = 1;
        while (!o_valid[k] && n < 40) begin
            if (scramble) begin
                tb_addr  = $urandom;
                tb_wdata = $urandom;
                tb_write = ~wr;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, ":latency"}, 32'(n), 32'(lat));
        check_val({tag, ":rdata"}, o_rdata[k], exp_rd);
        check_val({tag, ":error"}, 32'(o_err[k]), 32'(exp_err));
        @(posedge clk);
        #1;
        check_val({tag, ":valid_pulse"}, 32'(o_valid[k]), 32'd0);
        check_val({tag, ":rdata_hold"}, o_rdata[k], exp_rd);
        check_val({tag, ":ready_back"}, 32'(o_ready[k]), 32'd1);
    endtask

    // Hold req_valid high and measure the response-to-response period.
    task automatic tput(input int k, input int lat, input string tag);
        int n   = 0;
        int gap = 0;
        sel      = k;
        tb_write = 1'b0;
        tb_addr  = 32'h4;
        tb_valid = 1'b1;
        while (!o_valid[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!o_valid[k] && gap < 40);
        check_val({tag, ":period"}, 32'(gap), 32'(lat + 1));
        tb_valid = 1'b0;
        repeat (lat + 2) @(posedge clk);
        #1;
        check_val({tag, ":idle"}, 32'(o_ready[k]), 32'd1);
    endtask

    task automatic watch_quiet(input int k, input int ncyc, input string tag);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (o_valid[k]) seen++;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        tb_rst_all = 1'b1;
        tb_rst     = 1'b0;
        sel        = 0;
        tb_valid   = 1'b0;
        tb_write   = 1'b0;
        tb_addr    = '0;
        tb_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val("rst_ready", 32'(o_ready[k]), 32'd1);
            check_val("rst_valid", 32'(o_valid[k]), 32'd0);
            check_val("rst_rdata", o_rdata[k], 32'd0);
            check_val("rst_error", 32'(o_err[k]), 32'd0);
        end
        tb_rst_all = 1'b0;

        // LATENCY=2: preload, load, read-after-write with spacing
        do_txn(0, 2, 1'b1, 32'h0, 32'hfffffff0, 32'h0, 1'b0, 1'b0, "pre_w0", a0);
        do_txn(0, 2, 1'b1, 32'h4, 32'hffffffff, 32'h0, 1'b0, 1'b0, "pre_w1", a0);
        do_txn(0, 2, 1'b0, 32'h4, 32'h0, 32'hffffffff, 1'b0, 1'b0, "ld_w1", a0);
        do_txn(0, 2, 1'b1, 32'h8, 32'h0000000b, 32'h0, 1'b0, 1'b0, "st_w2", a0);
        do_txn(0, 2, 1'b0, 32'h8, 32'h0, 32'h0000000b, 1'b0, 1'b0, "ld_w2", a1);
        check_val("raw_spacing", 32'(a1 - a0), 32'd3);

        // Error cases and their lack of side effects
        do_txn(0, 2, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, "ld_misal", a0);
        do_txn(0, 2, 1'b0, 32'h00001000, 32'h0, 32'h0, 1'b1, 1'b0, "ld_oor", a0);
        do_txn(0, 2, 1'b0, 32'h4, 32'h0, 32'hffffffff, 1'b0, 1'b0, "ld_after_err", a0);
        do_txn(0, 2, 1'b1, 32'h6, 32'h55aa55aa, 32'h0, 1'b1, 1'b0, "st_misal", a0);
        do_txn(0, 2, 1'b0, 32'h4, 32'h0, 32'hffffffff, 1'b0, 1'b0, "ld_w1_kept", a0);
        do_txn(0, 2, 1'b0, 32'h8, 32'h0, 32'h0000000b, 1'b0, 1'b0, "ld_w2_kept", a0);
        do_txn(0, 2, 1'b1, 32'hffc, 32'h12345678, 32'h0, 1'b0, 1'b0, "st_last", a0);
        do_txn(0, 2, 1'b0, 32'hffc, 32'h0, 32'h12345678, 1'b0, 1'b0, "ld_last", a0);

        // Bus fields churned during WAIT must not leak into the transaction
        do_txn(0, 2, 1'b1, 32'h10, 32'ha5a5a5a5, 32'h0, 1'b0, 1'b1, "st_scr", a0);
        do_txn(0, 2, 1'b0, 32'h10, 32'h0, 32'ha5a5a5a5, 1'b0, 1'b1, "ld_scr", a0);
        do_txn(0, 2, 1'b0, 32'h0, 32'h0, 32'hfffffff0, 1'b0, 1'b1, "ld_w0_scr", a0);
        tput(0, 2, "tput2");

        // LATENCY=1
        do_txn(1, 1, 1'b1, 32'h0, 32'h00000011, 32'h0, 1'b0, 1'b0, "l1_st", a0);
        do_txn(1, 1, 1'b0, 32'h0, 32'h0, 32'h00000011, 1'b0, 1'b0, "l1_ld", a0);
        do_txn(1, 1, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0, "l1_err", a0);
        tput(1, 1, "tput1");

        // LATENCY=15
        do_txn(2, 15, 1'b1, 32'h4, 32'h15151515, 32'h0, 1'b0, 1'b0, "l15_st", a0);
        do_txn(2, 15, 1'b0, 32'h4, 32'h0, 32'h15151515, 1'b0, 1'b1, "l15_ld", a0);
        tput(2, 15, "tput15");

        // LATENCY=4: reset mid-transaction discards an uncommitted store
        do_txn(3, 4, 1'b1, 32'hc, 32'h12345678, 32'h0, 1'b0, 1'b0, "l4_st", a0);
        do_txn(3, 4, 1'b0, 32'hc, 32'h0, 32'h12345678, 1'b0, 1'b0, "l4_ld", a0);
        sel      = 3;
        tb_valid = 1'b1;
        tb_write = 1'b1;
        tb_addr  = 32'hc;
        tb_wdata = 32'hdeadbeef;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_rst   = 1'b1;
        check_val("rt_busy", 32'(o_ready[3]), 32'd0);
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        check_val("rt_ready", 32'(o_ready[3]), 32'd1);
        check_val("rt_valid", 32'(o_valid[3]), 32'd0);
        check_val("rt_rdata", o_rdata[3], 32'd0);
        check_val("rt_error", 32'(o_err[3]), 32'd0);
        watch_quiet(3, 8, "rt_quiet");
        do_txn(3, 4, 1'b0, 32'hc, 32'h0, 32'h12345678, 1'b0, 1'b0, "rt_ld", a0);

        // Reset in the same cycle as req_valid: nothing accepted
        sel      = 3;
        tb_valid = 1'b1;
        tb_rst   = 1'b1;
        tb_write = 1'b1;
        tb_addr  = 32'hc;
        tb_wdata = 32'hbad0bad0;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_rst   = 1'b0;
        check_val("rv_ready", 32'(o_ready[3]), 32'd1);
        watch_quiet(3, 8, "rv_quiet");
        do_txn(3, 4, 1'b0, 32'hc, 32'h0, 32'h12345678, 1'b0, 1'b0, "rv_ld", a0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
